// File: rtl/sap1_pkg.sv
// -----------------------------------------------------------------------------
// sap1_pkg
// Shared definitions for the SAP-1 style fetch path: bus widths, opcode
// constants, the fetch FSM state type and a small opcode extraction helper.
// -----------------------------------------------------------------------------
package sap1_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [3:0]        opcode_t;

    // Instruction set opcodes (upper nibble of an instruction word)
    localparam opcode_t OP_LDA = 4'h0;
    localparam opcode_t OP_ADD = 4'h1;
    localparam opcode_t OP_SUB = 4'h2;
    localparam opcode_t OP_OUT = 4'hE;
    localparam opcode_t OP_HLT = 4'hF;

    // Fetch FSM states
    typedef enum logic [2:0] {
        ADDR   = 3'd0,
        INC    = 3'd1,
        READ   = 3'd2,
        WAIT   = 3'd3,
        OPREAD = 3'd4,
        HALT   = 3'd5
    } fetch_state_t;

    // Upper nibble of an instruction word
    function automatic opcode_t opcode_of(input data_t word);
        return word[DATA_W-1:DATA_W-4];
    endfunction

endpackage

// File: rtl/program_counter.sv
// -----------------------------------------------------------------------------
// program_counter
// 4-bit program counter with synchronous clear, increment (wrapping 15 -> 0)
// and a parallel load that takes priority over increment.
//
// Ports:
//   clk        in   clock
//   rst_n      in   synchronous active-low clear
//   inc        in   advance by one
//   load       in   load load_value
//   load_value in   value for load
//   count      out  current program counter
// -----------------------------------------------------------------------------
module program_counter
    import sap1_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_value,
    output logic [ADDR_W-1:0] count
);

    addr_t count_r;

    // Counter register: clear, load or increment
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= addr_t'(0);
        end else if (load) begin
            count_r <= load_value;
        end else if (inc) begin
            // natural modulo-16 wrap of the 4-bit sum
            count_r <= count_r + addr_t'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch and operand read front end of a SAP-1 style CPU.
// Sequence: ADDR (MAR <= PC) -> INC (PC++) -> READ (IR <= memory) -> WAIT.
// In WAIT the controller either requests an operand read (OPREAD) or signals
// that the instruction is done (back to ADDR). A HALT opcode stops fetching
// until reset.
//
// Configuration macro: FETCH_JUMP_EN -- when defined, jmp_valid in WAIT loads
// PC from jmp_addr before the next fetch. When undefined, jmp_* are ignored.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   synchronous active-low reset
//   mem_enable   out  1 = memory tristated, 0 = memory drives w_bus
//   mem_address  out  memory address (MAR)
//   w_bus        in   memory read data
//   instr_valid  out  IR holds an instruction awaiting execution
//   ir_opcode    out  IR[7:4]
//   ir_operand   out  IR[3:0]
//   opr_req      in   operand read request (WAIT only)
//   opr_addr     in   operand address
//   opr_data     out  last operand read result
//   opr_valid    out  one-cycle strobe for opr_data
//   exec_done    in   current instruction finished (WAIT only)
//   jmp_valid    in   PC load request (FETCH_JUMP_EN only)
//   jmp_addr     in   PC load value
//   pc           out  program counter
//   halted       out  halt flag
// -----------------------------------------------------------------------------
module fetch_unit
    import sap1_pkg::*;
#(
    parameter logic [3:0] HALT_OPCODE = 4'hF
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_enable,
    output logic [ADDR_W-1:0] mem_address,
    input  logic [DATA_W-1:0] w_bus,
    output logic              instr_valid,
    output logic [3:0]        ir_opcode,
    output logic [3:0]        ir_operand,
    input  logic              opr_req,
    input  logic [ADDR_W-1:0] opr_addr,
    output logic [DATA_W-1:0] opr_data,
    output logic              opr_valid,
    input  logic              exec_done,
    input  logic              jmp_valid,
    input  logic [ADDR_W-1:0] jmp_addr,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    fetch_state_t state_r;
    addr_t        mar_r;
    data_t        ir_r;
    data_t        opr_data_r;
    logic         opr_valid_r;
    logic         halted_r;
    logic         mem_enable_r;
    logic         instr_valid_r;

    addr_t        pc_s;
    logic         pc_inc_s;
    logic         jump_take_s;

    // Program counter control decoded from the current state
    always_comb begin
        pc_inc_s    = 1'b0;
        jump_take_s = 1'b0;
        if (state_r == INC) begin
            pc_inc_s = 1'b1;
        end else begin
            pc_inc_s = 1'b0;
        end
`ifdef FETCH_JUMP_EN
        // operand requests win over jumps; jumps win over exec_done
        if ((state_r == WAIT) && !opr_req && jmp_valid) begin
            jump_take_s = 1'b1;
        end else begin
            jump_take_s = 1'b0;
        end
`endif
    end

`ifndef FETCH_JUMP_EN
    logic unused_jump_s;
    assign unused_jump_s = ^{jmp_valid, jmp_addr};
`endif

    program_counter u_pc (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc        (pc_inc_s),
        .load       (jump_take_s),
        .load_value (jmp_addr),
        .count      (pc_s)
    );

    // Fetch FSM with registered outputs; mem_enable and instr_valid are
    // computed for the state being entered so they line up with state_r.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ADDR;
            mar_r         <= addr_t'(0);
            ir_r          <= data_t'(0);
            opr_data_r    <= data_t'(0);
            opr_valid_r   <= 1'b0;
            halted_r      <= 1'b0;
            mem_enable_r  <= 1'b1;
            instr_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ADDR: begin
                    mar_r         <= pc_s;
                    state_r       <= INC;
                    mem_enable_r  <= 1'b1;
                    instr_valid_r <= 1'b0;
                    opr_valid_r   <= 1'b0;
                end
                INC: begin
                    state_r       <= READ;
                    mem_enable_r  <= 1'b0;
                    instr_valid_r <= 1'b0;
                    opr_valid_r   <= 1'b0;
                end
                READ: begin
                    ir_r         <= w_bus;
                    mem_enable_r <= 1'b1;
                    opr_valid_r  <= 1'b0;
                    if (opcode_of(w_bus) == HALT_OPCODE) begin
                        state_r       <= HALT;
                        halted_r      <= 1'b1;
                        instr_valid_r <= 1'b0;
                    end else begin
                        state_r       <= WAIT;
                        instr_valid_r <= 1'b1;
                    end
                end
                WAIT: begin
                    // opr_valid is a single-cycle strobe after OPREAD
                    opr_valid_r <= 1'b0;
                    if (opr_req) begin
                        mar_r         <= opr_addr;
                        state_r       <= OPREAD;
                        mem_enable_r  <= 1'b0;
                        instr_valid_r <= 1'b1;
                    end else if (jump_take_s || exec_done) begin
                        state_r       <= ADDR;
                        mem_enable_r  <= 1'b1;
                        instr_valid_r <= 1'b0;
                    end else begin
                        state_r       <= WAIT;
                        mem_enable_r  <= 1'b1;
                        instr_valid_r <= 1'b1;
                    end
                end
                OPREAD: begin
                    opr_data_r    <= w_bus;
                    opr_valid_r   <= 1'b1;
                    state_r       <= WAIT;
                    mem_enable_r  <= 1'b1;
                    instr_valid_r <= 1'b1;
                end
                HALT: begin
                    state_r       <= HALT;
                    halted_r      <= 1'b1;
                    mem_enable_r  <= 1'b1;
                    instr_valid_r <= 1'b0;
                    opr_valid_r   <= 1'b0;
                end
                default: begin
                    // unreachable encoding: restart fetching safely
                    state_r       <= ADDR;
                    mem_enable_r  <= 1'b1;
                    instr_valid_r <= 1'b0;
                    opr_valid_r   <= 1'b0;
                end
            endcase
        end
    end

    assign mem_enable  = mem_enable_r;
    assign mem_address = mar_r;
    assign instr_valid = instr_valid_r;
    assign ir_opcode   = ir_r[7:4];
    assign ir_operand  = ir_r[3:0];
    assign opr_data    = opr_data_r;
    assign opr_valid   = opr_valid_r;
    assign pc          = pc_s;
    assign halted      = halted_r;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter HALT_OPCODE, default 4'hF, the opcode that stops fetching.
REQ-002 The block SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 The block SHALL have port mem_enable  output  1  program memory output control: 1 tristates memory, 0 makes it drive w_bus.
REQ-005 The block SHALL have port mem_address  output  4  program memory address, driven from the MAR register.
REQ-006 The block SHALL have port w_bus  input  8  data read from program memory.
REQ-007 The block SHALL have port instr_valid  output  1  IR holds a fetched instruction awaiting execution.
REQ-008 The block SHALL have ports ir_opcode and ir_operand  output  4 each  IR[7:4] and IR[3:0].
REQ-009 The block SHALL have ports opr_req (input, 1) and opr_addr (input, 4)  controller operand-read request and its address.
REQ-010 The block SHALL have ports opr_data (output, 8) and opr_valid (output, 1)  operand read result and its one-cycle strobe.
REQ-011 The block SHALL have port exec_done  input  1  controller pulse: current instruction finished.
REQ-012 The block SHALL have ports jmp_valid (input, 1) and jmp_addr (input, 4)  PC load request; used only under FETCH_JUMP_EN.
REQ-013 The block SHALL have ports pc (output, 4) and halted (output, 1)  program counter value and halt flag.

Function
REQ-014 FSM states SHALL be ADDR, INC, READ, WAIT, OPREAD, HALT.
REQ-015 ADDR SHALL load MAR <= PC, then go to INC.
REQ-016 INC SHALL set PC <= PC+1 modulo 16 (15 wraps to 0), then go to READ.
REQ-017 READ SHALL drive mem_enable=0 combinationally and capture IR <= w_bus at the clock edge ending the cycle.
REQ-018 From READ, the next state SHALL be HALT if w_bus[7:4]==HALT_OPCODE, otherwise WAIT.
REQ-019 mem_enable SHALL be 1 in every state except READ and OPREAD.
REQ-020 instr_valid SHALL be 1 exactly while in WAIT or OPREAD; the first instruction is valid 3 cycles after reset release.
REQ-021 In WAIT, opr_req=1 SHALL load MAR <= opr_addr and go to OPREAD.
REQ-022 OPREAD SHALL drive mem_enable=0, register opr_data <= w_bus, pulse opr_valid for the following cycle, and return to WAIT.
REQ-023 In WAIT, exec_done=1 with opr_req=0 SHALL go to ADDR; opr_req takes priority and a simultaneous exec_done SHALL be dropped.
REQ-024 opr_req and exec_done SHALL be ignored outside WAIT; opr_data SHALL hold its value until the next operand read.
REQ-025 HALT SHALL hold halted=1, instr_valid=0, mem_enable=1 and ignore all inputs until reset.

Reset
REQ-026 While rst_n=0 at a clock edge, the block SHALL set state=ADDR, PC=0, MAR=0, IR=0, opr_data=0, opr_valid=0, halted=0 and mem_enable=1.
REQ-027 Reset asserted in any state, including mid-READ or mid-OPREAD, SHALL abandon the operation with no partial IR or opr_data update.

Configuration
REQ-028 With macro FETCH_JUMP_EN defined, jmp_valid=1 in WAIT (opr_req=0) SHALL set PC <= jmp_addr and go to ADDR, taking priority over exec_done.
REQ-029 Without FETCH_JUMP_EN, jmp_valid and jmp_addr SHALL be ignored, and PC SHALL change only by increment and reset.

Structure
REQ-030 Shared package sap1_pkg SHALL hold the address width (4), data width (8), opcode constants (including 4'hE OUT and 4'hF HLT) and the FSM state type.
REQ-031 PC SHALL be a sub-module program_counter (clear, increment, optional load), instantiated once.

Verification
REQ-032 Memory [0]=8'h06, [1]=8'h17; release reset -> cycle 3: instr_valid=1, ir_opcode=0, ir_operand=6, pc=1; exec_done -> 3 cycles later ir=8'h17, pc=2.
REQ-033 In WAIT, opr_req with opr_addr=4'hE where [E]=8'h01 -> OPREAD with mem_enable=0 and mem_address=E, then opr_valid=1 and opr_data=8'h01 one cycle.
REQ-034 PC=15, [F]=8'h10, exec_done -> fetches 8'h10 from address F, pc=0.
REQ-035 [2]=8'hF0 -> after the READ at address 2, halted=1 and instr_valid=0; exec_done and opr_req produce no change and mem_enable stays 1.
REQ-036 rst_n=0 during READ -> next cycle pc=0, IR=0, mem_enable=1; first fetch then restarts from address 0.
REQ-037 FETCH_JUMP_EN defined, jmp_valid=1 with jmp_addr=4'h8 in WAIT -> next fetch at address 8, pc=9; with the macro undefined -> jump ignored.
